fast_segment_test: RTL and testbench

- Consumer end of the Bresenham circle stream produced by draw_circle.
- Receives the N_CIRCLE intensities sampled on the radius-3 circle around a candidate pixel, classifies each as bright, dark or similar against the centre intensity and a threshold, and runs the FAST contiguous-arc test, including arcs that wrap around the circle.
- Sits between the circle pixel fetch and orientation/NMS stages; emits one corner decision per candidate.

---
 rtl/fast_segment_test.sv | 157 +++++++++++++++
 tb/tb_fast_segment_test.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fast_segment_test.sv
// fast_segment_test: FAST segment test on a stream of circle pixels.
// Classifies each pixel, counts bright/dark runs and replays the arc head to catch wrap-around arcs.
`default_nettype none

module fast_segment_test #(
  parameter int PIX_W    = 8,
  parameter int N_CIRCLE = 16,
  parameter int N_CONTIG = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PIX_W-1:0]              center_px,
  input  logic [PIX_W-1:0]              thresh,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  output logic                          pix_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          is_corner,
  output logic                          polarity,
  output logic [$clog2(N_CIRCLE+1)-1:0] max_run
);

  localparam int RUN_W = $clog2(N_CIRCLE + 1);
  localparam logic [RUN_W-1:0] c_full      = RUN_W'(N_CIRCLE);
  localparam logic [RUN_W-1:0] c_last_beat = RUN_W'(N_CIRCLE - 1);
  localparam logic [RUN_W-1:0] c_last_wrap = RUN_W'(N_CONTIG - 2);
  localparam logic [RUN_W-1:0] c_contig    = RUN_W'(N_CONTIG);
  localparam logic [1:0] c_cls_sim    = 2'd0;
  localparam logic [1:0] c_cls_bright = 2'd1;
  localparam logic [1:0] c_cls_dark   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRAP    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [PIX_W-1:0]      r_center, r_thresh;
  logic [2*N_CIRCLE-1:0] r_cls;
  logic [RUN_W-1:0]      r_cnt;
  logic [RUN_W-1:0]      r_run_b, r_run_d, r_best_b, r_best_d;
  logic                  r_done, r_is_corner, r_polarity;
  logic [RUN_W-1:0]      r_max_run;

  logic [PIX_W:0]   w_hi, w_lo_sum;
  logic [1:0]       w_new_cls, w_cls;
  logic             w_accept;
  logic [RUN_W-1:0] w_run_b_nx, w_run_d_nx, w_best_b_nx, w_best_d_nx;

  // Widened sums so centre+threshold never wraps.
  assign w_hi      = {1'b0, r_center} + {1'b0, r_thresh};
  assign w_lo_sum  = {1'b0, pix_data} + {1'b0, r_thresh};
  assign w_new_cls = ({1'b0, pix_data} > w_hi)     ? c_cls_bright :
                     (w_lo_sum < {1'b0, r_center}) ? c_cls_dark   : c_cls_sim;

  assign w_accept = (r_state == S_COLLECT) && pix_valid;
  assign w_cls    = (r_state == S_WRAP) ? r_cls[1:0] : w_new_cls;

  assign w_run_b_nx  = (w_cls != c_cls_bright) ? '0 :
                       (r_run_b == c_full) ? c_full : r_run_b + RUN_W'(1);
  assign w_run_d_nx  = (w_cls != c_cls_dark) ? '0 :
                       (r_run_d == c_full) ? c_full : r_run_d + RUN_W'(1);
  assign w_best_b_nx = (w_run_b_nx > r_best_b) ? w_run_b_nx : r_best_b;
  assign w_best_d_nx = (w_run_d_nx > r_best_d) ? w_run_d_nx : r_best_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_accept && (r_cnt == c_last_beat)) w_next = S_WRAP;
      S_WRAP:    if (r_cnt == c_last_wrap) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_center    <= '0;
      r_thresh    <= '0;
      r_cls       <= '0;
      r_cnt       <= '0;
      r_run_b     <= '0;
      r_run_d     <= '0;
      r_best_b    <= '0;
      r_best_d    <= '0;
      r_done      <= 1'b0;
      r_is_corner <= 1'b0;
      r_polarity  <= 1'b0;
      r_max_run   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_center    <= center_px;
            r_thresh    <= thresh;
            r_cnt       <= '0;
            r_run_b     <= '0;
            r_run_d     <= '0;
            r_best_b    <= '0;
            r_best_d    <= '0;
            r_is_corner <= 1'b0;
            r_polarity  <= 1'b0;
            r_max_run   <= '0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            // Entry 0 ends up holding the first pixel after N_CIRCLE shifts.
            r_cls    <= {w_new_cls, r_cls[2*N_CIRCLE-1:2]};
            r_cnt    <= (r_cnt == c_last_beat) ? '0 : r_cnt + RUN_W'(1);
            r_run_b  <= w_run_b_nx;
            r_run_d  <= w_run_d_nx;
            r_best_b <= w_best_b_nx;
            r_best_d <= w_best_d_nx;
          end
        end
        S_WRAP: begin
          r_cls    <= {r_cls[1:0], r_cls[2*N_CIRCLE-1:2]};
          r_cnt    <= r_cnt + RUN_W'(1);
          r_run_b  <= w_run_b_nx;
          r_run_d  <= w_run_d_nx;
          r_best_b <= w_best_b_nx;
          r_best_d <= w_best_d_nx;
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_is_corner <= (r_best_b >= c_contig) || (r_best_d >= c_contig);
          r_polarity  <= (r_best_b >= c_contig);
          r_max_run   <= (r_best_b >= r_best_d) ? r_best_b : r_best_d;
        end
        default: ;
      endcase
    end
  end

  assign pix_ready = (r_state == S_COLLECT);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign is_corner = r_is_corner;
  assign polarity  = r_polarity;
  assign max_run   = r_max_run;

endmodule

`default_nettype wire

// File: tb/tb_fast_segment_test.sv
// tb_fast_segment_test: vector table + scoreboard bench for fast_segment_test.
`default_nettype none

module tb_fast_segment_test;

  typedef logic [15:0][7:0] px_t;

  typedef struct {
    logic [7:0] c;
    logic [7:0] t;
    px_t        px;
    bit         gaps;
    bit         inject;
    logic       ec;
    logic       ep;
    logic [4:0] em;
  } vec_t;

  typedef struct {
    logic       ec;
    logic       ep;
    logic [4:0] em;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] center_px = '0;
  logic [7:0] thresh = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready, busy, done, is_corner, polarity;
  logic [4:0] max_run;

  int   errors = 0;
  int   checks = 0;
  logic [4:0] prev_max = '0;
  exp_t sb[$];
  vec_t vecs[14];

  fast_segment_test #(.PIX_W(8), .N_CIRCLE(16), .N_CONTIG(9)) dut (
    .clk(clk), .rst(rst), .start(start), .center_px(center_px), .thresh(thresh),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy),
    .done(done), .is_corner(is_corner), .polarity(polarity), .max_run(max_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic px_t arc(input logic [7:0] a, input logic [7:0] b, input int s, input int len);
    px_t r;
    for (int i = 0; i < 16; i++) r[i] = b;
    for (int k = 0; k < len; k++) r[(s + k) % 16] = a;
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic [7:0] t, input px_t px,
                              input bit g, input bit inj, input logic ec, input logic ep,
                              input logic [4:0] em);
    vec_t v;
    v.c = c; v.t = t; v.px = px; v.gaps = g; v.inject = inj;
    v.ec = ec; v.ep = ep; v.em = em;
    return v;
  endfunction

  task automatic feed(input vec_t v, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      if (v.gaps) begin
        pix_valid = 1'b0;
        pix_data  = 8'hxx;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_data  = v.px[i];
      if (v.inject && i == 5) begin
        start = 1'b1; center_px = 8'd0; thresh = 8'd0;
      end
      @(negedge clk);
      if (v.inject && i == 5) begin
        start = 1'b0;
        chk("busy_during_collect", busy, 1);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   n;
    chk({tag, "_hold_prev"}, max_run, prev_max);
    start = 1'b1; center_px = v.c; thresh = v.t;
    e.ec = v.ec; e.ep = v.ep; e.em = v.em;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clear_max"}, max_run, 0);
    chk({tag, "_clear_corner"}, is_corner, 0);
    chk({tag, "_busy"}, busy, 1);
    feed(v, 16);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got no done expected done", tag);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, n, 9);
      chk({tag, "_is_corner"}, is_corner, e.ec);
      chk({tag, "_polarity"}, polarity, e.ep);
      chk({tag, "_max_run"}, max_run, e.em);
      chk({tag, "_busy_at_done"}, busy, 0);
      prev_max = e.em;
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  initial begin
    px_t alt;
    bit  seen;
    for (int i = 0; i < 16; i++) alt[i] = (i % 2 == 0) ? 8'd200 : 8'd0;

    vecs[0]  = mk(100, 20, arc(200, 200, 0, 16), 0, 0, 1, 1, 16);
    vecs[1]  = mk(100, 20, arc(50, 100, 12, 9),  0, 0, 1, 0, 9);
    vecs[2]  = mk(100, 20, arc(121, 120, 0, 8),  0, 0, 0, 0, 8);
    vecs[3]  = mk(100, 20, arc(121, 121, 0, 16), 0, 0, 1, 1, 16);
    vecs[4]  = mk(10, 20,  arc(0, 0, 0, 16),     0, 0, 0, 0, 0);
    vecs[5]  = mk(100, 20, arc(200, 100, 10, 9), 0, 0, 1, 1, 9);
    vecs[6]  = mk(100, 20, arc(0, 0, 0, 16),     0, 0, 1, 0, 16);
    vecs[7]  = mk(100, 20, alt,                  0, 0, 0, 0, 1);
    vecs[8]  = mk(100, 20, arc(50, 100, 3, 8),   0, 0, 0, 0, 8);
    vecs[9]  = mk(100, 20, arc(200, 100, 0, 9),  0, 0, 1, 1, 9);
    vecs[10] = mk(100, 20, arc(0, 100, 2, 15),   0, 0, 1, 0, 15);
    vecs[11] = mk(100, 20, arc(200, 200, 0, 16), 1, 0, 1, 1, 16);
    vecs[12] = mk(100, 20, arc(50, 100, 12, 9),  1, 0, 1, 0, 9);
    vecs[13] = mk(100, 20, arc(121, 120, 0, 8),  1, 1, 0, 0, 8);

    repeat (2) @(negedge clk);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", pix_ready, 0);
    chk("reset_corner", is_corner, 0);
    chk("reset_polarity", polarity, 0);
    chk("reset_max_run", max_run, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a candidate after seven beats; no result may appear for it.
    start = 1'b1; center_px = 8'd100; thresh = 8'd20;
    @(negedge clk);
    start = 1'b0;
    feed(vecs[0], 7);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pix_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_corner", is_corner, 0);
    chk("midrst_polarity", polarity, 0);
    chk("midrst_max_run", max_run, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_max = '0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_vec(vecs[1], "post_rst");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
